// File: rtl/serial_sequence_tx_if.sv
// Handshake and serial-output bundle for serial_sequence_tx.
// master = word source / consumer of the serial stream, slave = the transmitter.
interface serial_sequence_tx_if #(
  parameter int WIDTH = 8
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             output_sequence;
  logic             out_valid;
  logic             done;
  logic             busy;

  modport master (
    output in_valid, in_data, in_len,
    input  in_ready, output_sequence, out_valid, done, busy
  );

  modport slave (
    input  in_valid, in_data, in_len,
    output in_ready, output_sequence, out_valid, done, busy
  );
endinterface

// File: rtl/serial_sequence_tx.sv
// Bit-serial transmitter: takes a word plus bit count over valid/ready and shifts it out
// MSB-first, one bit per clock, with an optional idle gap after every word.
module serial_sequence_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  serial_sequence_tx_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [LEN_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             seq_q;
  logic             valid_q;
  logic             done_q;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             last_bit;
  logic             ready;
  logic             accept;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    eff_len = bus.in_len;
    if (bus.in_len == '0 || bus.in_len > FULL_LEN) eff_len = FULL_LEN;
    // Left-justify the word so the first bit to send always sits at the MSB.
    aligned = bus.in_data << (FULL_LEN - eff_len);
  end

  // cnt_q holds the number of bits still to follow the one currently on the pin.
  assign last_bit = (state == S_SHIFT) && (cnt_q == '0);
  assign ready    = !reset && ((state == S_IDLE) || ((GAP == 0) && last_bit));
  assign accept   = bus.in_valid && ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      seq_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // Accept from IDLE or on the last bit of the previous word (back-to-back).
        state   <= S_SHIFT;
        seq_q   <= aligned[WIDTH-1];
        shift_q <= aligned << 1;
        cnt_q   <= eff_len - LEN_W'(1);
        valid_q <= 1'b1;
        done_q  <= (eff_len == LEN_W'(1));
      end else begin
        case (state)
          S_SHIFT: begin
            if (cnt_q != '0) begin
              seq_q   <= shift_q[WIDTH-1];
              shift_q <= shift_q << 1;
              cnt_q   <= cnt_q - LEN_W'(1);
              done_q  <= (cnt_q == LEN_W'(1));
            end else begin
              seq_q   <= IDLE_LEVEL;
              valid_q <= 1'b0;
              if (GAP > 0) begin
                state <= S_GAP;
                gap_q <= GAP_W'(GAP - 1);
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_GAP: begin
            if (gap_q == '0) state <= S_IDLE;
            else             gap_q <= gap_q - GAP_W'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready        = ready;
  assign bus.output_sequence = seq_q;
  assign bus.out_valid       = valid_q;
  assign bus.done            = done_q;
  assign bus.busy            = (state != S_IDLE);
endmodule
